sync_debounce_edge: RTL and testbench

- Consumes the output of the two-flop synchronizer. Its input is already in the dst_clk domain.
- Filters the synchronized level for bounce and glitches, and commits a change only after it is held for DEBOUNCE_CYCLES consecutive samples.
- Emits a clean level, single-cycle rise and fall pulses, and event and glitch counters for downstream control logic and status registers.

---
 rtl/sync_debounce_edge.sv | 181 ++++++++++++++++++
 tb/tb_sync_debounce_edge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_edge.sv
// Debounce filter and edge detector for an already-synchronized level.
// A level change is committed only after the new value has been seen on
// DEBOUNCE_CYCLES consecutive dst_clk edges. A shorter excursion counts as
// a glitch. Commits produce a one-cycle rise or fall pulse and advance a
// wrapping edge counter. Glitches advance a saturating glitch counter.
// Every output comes straight from a flop.

module sync_debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             dst_clk,
  input  logic             rst,
  input  logic             sync_data,
  input  logic             clear_counts,
  output logic             stable_data,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] glitch_count
);

  // The run counter must be able to hold DEBOUNCE_CYCLES itself, because the
  // commit test compares run+1 against it.
  localparam int               RUN_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(DEBOUNCE_CYCLES);
  localparam bit               SINGLE  = (DEBOUNCE_CYCLES == 1);

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_CHECK_HIGH  = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_CHECK_LOW   = 2'd3;

  // Edge counter: plain modulo-2^CNT_W increment.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  // Glitch counter: increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  logic [1:0]       state_q,  state_d;
  logic [RUN_W-1:0] run_q,    run_d;
  logic             stable_q, stable_d;
  logic             rise_q,   rise_d;
  logic             fall_q,   fall_d;
  logic [CNT_W-1:0] edge_q,   edge_d;
  logic [CNT_W-1:0] glitch_q, glitch_d;
  logic [RUN_W-1:0] run_inc;
  logic             glitch_ev;

  assign run_inc = run_q + RUN_ONE;

  // Debounce FSM: track the candidate level and decide commit or glitch.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    stable_d  = stable_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_ev = 1'b0;
    case (state_q)
      ST_STABLE_LOW: begin
        if (sync_data) begin
          if (SINGLE) begin
            state_d  = ST_STABLE_HIGH;
            stable_d = 1'b1;
            rise_d   = 1'b1;
            run_d    = '0;
          end else begin
            state_d = ST_CHECK_HIGH;
            run_d   = RUN_ONE;
          end
        end
      end
      ST_CHECK_HIGH: begin
        if (sync_data) begin
          if (run_inc == RUN_TGT) begin
            state_d  = ST_STABLE_HIGH;
            stable_d = 1'b1;
            rise_d   = 1'b1;
            run_d    = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          // Fell back before the run completed: abandon the rise.
          state_d   = ST_STABLE_LOW;
          run_d     = '0;
          glitch_ev = 1'b1;
        end
      end
      ST_STABLE_HIGH: begin
        if (!sync_data) begin
          if (SINGLE) begin
            state_d  = ST_STABLE_LOW;
            stable_d = 1'b0;
            fall_d   = 1'b1;
            run_d    = '0;
          end else begin
            state_d = ST_CHECK_LOW;
            run_d   = RUN_ONE;
          end
        end
      end
      ST_CHECK_LOW: begin
        if (!sync_data) begin
          if (run_inc == RUN_TGT) begin
            state_d  = ST_STABLE_LOW;
            stable_d = 1'b0;
            fall_d   = 1'b1;
            run_d    = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          // Rose again before the run completed: abandon the fall.
          state_d   = ST_STABLE_HIGH;
          run_d     = '0;
          glitch_ev = 1'b1;
        end
      end
      default: begin
        state_d  = ST_STABLE_LOW;
        run_d    = '0;
        stable_d = 1'b0;
      end
    endcase
  end

  // Status counters: a clear wins over a same-cycle event.
  always_comb begin
    edge_d   = edge_q;
    glitch_d = glitch_q;
    if (clear_counts) begin
      edge_d   = '0;
      glitch_d = '0;
    end else begin
      if (rise_d || fall_d) begin
        edge_d = wrap_inc(edge_q);
      end
      if (glitch_ev) begin
        glitch_d = sat_inc(glitch_q);
      end
    end
  end

  // State, outputs and counters, all cleared by the asynchronous reset.
  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STABLE_LOW;
      run_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      edge_q   <= '0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      edge_q   <= edge_d;
      glitch_q <= glitch_d;
    end
  end

  assign stable_data  = stable_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign edge_count   = edge_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Testbench for sync_debounce_edge.
// Contains one instance with a 4-cycle debounce and one with a 1-cycle debounce.
// Expected values are hand-computed.

module tb_sync_debounce_edge;

  logic       clk = 1'b0;
  logic       rst;
  logic       sd4, sd1, clr, clr1;
  logic       st4, rs4, fl4, st1, rs1, fl1;
  logic [7:0] ec4, gc4, ec1, gc1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut4 (
    .dst_clk(clk), .rst(rst), .sync_data(sd4), .clear_counts(clr),
    .stable_data(st4), .rise_pulse(rs4), .fall_pulse(fl4),
    .edge_count(ec4), .glitch_count(gc4)
  );

  sync_debounce_edge #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
    .dst_clk(clk), .rst(rst), .sync_data(sd1), .clear_counts(clr1),
    .stable_data(st1), .rise_pulse(rs1), .fall_pulse(fl1),
    .edge_count(ec1), .glitch_count(gc1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait for the next rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rise and fall pulses of either instance must never be high together.
  always @(negedge clk) begin
    check("excl4", int'(rs4 & fl4), 0);
    check("excl1", int'(rs1 & fl1), 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic sd;
    logic clr;
    logic st;
    logic rs;
    logic fl;
    int   ec;
    int   gc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic sd, input logic c, input logic st,
                     input logic rs, input logic fl, input int ec, input int gc);
    vec_t v;
    v.sd = sd; v.clr = c; v.st = st; v.rs = rs; v.fl = fl; v.ec = ec; v.gc = gc;
    tbl.push_back(v);
  endtask

  initial begin
    int rise_seen;
    int pulses;
    logic prev;
    logic v;

    rst = 1'b1; sd4 = 1'b0; sd1 = 1'b0; clr = 1'b0; clr1 = 1'b0;

    //       sd    clr   st    rs    fl    ec gc
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0); // run=1
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0); // run=2
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0); // run=3
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0); // rise commit
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0); // fall commit
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1); // glitch, low side
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1); // rise commit
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 2); // glitch, high side
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 2);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0); // clear
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0); // clear on commit edge
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); // clear on glitch edge

    // Reset state.
    tick();
    tick();
    check("rst_stable", int'(st4), 0);
    check("rst_rise",   int'(rs4), 0);
    check("rst_fall",   int'(fl4), 0);
    check("rst_edge",   int'(ec4), 0);
    check("rst_glitch", int'(gc4), 0);
    rst = 1'b0;

    // Table-driven vectors, 4-cycle debounce.
    foreach (tbl[i]) begin
      sd4 = tbl[i].sd;
      clr = tbl[i].clr;
      tick();
      check($sformatf("v%0d_stable", i), int'(st4), int'(tbl[i].st));
      check($sformatf("v%0d_rise", i),   int'(rs4), int'(tbl[i].rs));
      check($sformatf("v%0d_fall", i),   int'(fl4), int'(tbl[i].fl));
      check($sformatf("v%0d_edge", i),   int'(ec4), tbl[i].ec);
      check($sformatf("v%0d_glitch", i), int'(gc4), tbl[i].gc);
    end
    clr = 1'b0;

    // 300 short high excursions: glitch_count saturates at 255.
    rise_seen = 0;
    for (int g = 0; g < 300; g++) begin
      for (int c = 0; c < 4; c++) begin
        sd4 = (c < 3);
        tick();
        if (rs4 || st4) rise_seen++;
      end
      if (g == 0)   check("gsat_first", int'(gc4), 1);
      if (g == 254) check("gsat_255",   int'(gc4), 255);
    end
    check("gsat_final",   int'(gc4), 255);
    check("gsat_nopulse", rise_seen, 0);
    check("gsat_edge",    int'(ec4), 0);

    // 256 committed edges: edge_count wraps back to 0.
    pulses = 0;
    for (int e = 0; e < 256; e++) begin
      sd4 = (e % 2 == 0);
      for (int c = 0; c < 4; c++) begin
        tick();
        if (rs4 || fl4) pulses++;
      end
      if (e == 254) check("wrap_255", int'(ec4), 255);
    end
    check("wrap_zero",   int'(ec4), 0);
    check("wrap_pulses", pulses, 256);
    check("wrap_stable", int'(st4), 0);

    // Reset in CHECK_HIGH with run=2 and sync_data held high.
    sd4 = 1'b1;
    tick();
    tick();
    check("rh_pre_stable", int'(st4), 0);
    #1 rst = 1'b1;
    #1;
    check("rh_async_glitch", int'(gc4), 0);
    check("rh_async_stable", int'(st4), 0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("rh_post%0d_rise", k), int'(rs4), 0);
      check($sformatf("rh_post%0d_stable", k), int'(st4), 0);
    end
    tick();
    check("rh_post4_rise",   int'(rs4), 1);
    check("rh_post4_stable", int'(st4), 1);
    check("rh_post4_edge",   int'(ec4), 1);
    tick();
    check("rh_post5_rise",   int'(rs4), 0);

    // Reset in CHECK_LOW clears the high stable level asynchronously.
    sd4 = 1'b0;
    tick();
    tick();
    check("rl_pre_stable", int'(st4), 1);
    #1 rst = 1'b1;
    #1;
    check("rl_async_stable", int'(st4), 0);
    check("rl_async_edge",   int'(ec4), 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rs4 || fl4 || st4) pulses++;
    end
    check("rl_quiet", pulses, 0);

    // Reset right after a commit drops the pulse in flight.
    sd4 = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("rp_rise", int'(rs4), 1);
    #1 rst = 1'b1;
    #1;
    check("rp_drop_rise",   int'(rs4), 0);
    check("rp_drop_stable", int'(st4), 0);
    tick();
    sd4 = 1'b0;
    rst = 1'b0;

    // 1-cycle debounce: output follows input one cycle later.
    prev = 1'b0;
    v    = 1'b0;
    for (int k = 0; k < 12; k++) begin
      v   = ~v;
      sd1 = v;
      tick();
      check($sformatf("d1_%0d_stable", k), int'(st1), int'(v));
      check($sformatf("d1_%0d_rise", k),   int'(rs1), int'(v & ~prev));
      check($sformatf("d1_%0d_fall", k),   int'(fl1), int'(~v & prev));
      prev = v;
    end
    check("d1_edge",   int'(ec1), 12);
    check("d1_glitch", int'(gc1), 0);
    tick();
    check("d1_hold_rise", int'(rs1), 0);
    check("d1_hold_fall", int'(fl1), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
